// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with the F->D pipeline register.
// Keeps at most one instruction-memory request outstanding. A one-entry hold
// buffer catches a response that returns while decode is stalled. Responses
// still in flight when a redirect arrives are dropped.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallD_i,
   input  logic        FlushD_i,
   input  logic        PCSrcE_i,
   input  logic [31:0] PCTargetE_i,
   output logic        ImemReq_o,
   output logic [31:0] ImemAddr_o,
   input  logic        ImemReady_i,
   input  logic        ImemRvalid_i,
   input  logic [31:0] ImemRdata_i,
   output logic [31:0] InstrD_o,
   output logic [31:0] PCD_o,
   output logic [31:0] PCPlus4D_o,
   output logic        ValidD_o
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned WORD_W = XLEN - 2;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_KILL = 2'd2
   } state_e;

   state_e              state_q,    state_d;
   logic [WORD_W-1:0]   pcf_q,      pcf_d;      // next fetch word address
   logic [XLEN-1:0]     req_pc_q,   req_pc_d;   // address of outstanding request
   logic [XLEN-1:0]     h_instr_q,  h_instr_d;
   logic [XLEN-1:0]     h_pc_q,     h_pc_d;
   logic                h_valid_q,  h_valid_d;
   logic [XLEN-1:0]     instr_d_q,  instr_d_d;
   logic [XLEN-1:0]     pcd_q,      pcd_d;
   logic [XLEN-1:0]     pcp4d_q,    pcp4d_d;
   logic                valid_d_q,  valid_d_d;

   logic                issue_c;
   logic                hs_c;
   logic                resp_c;
   logic                unused_tgt_lsb;

   // Redirect targets are word aligned; the low bits are ignored.
   assign unused_tgt_lsb = ^PCTargetE_i[1:0];

   // Request issue: REQ, or back-to-back from WAIT when decode takes the response.
   always_comb begin
      issue_c = 1'b0;
      if (!rst && !PCSrcE_i && !h_valid_q) begin
         case (state_q)
            ST_REQ:  issue_c = 1'b1;
            ST_WAIT: issue_c = ImemRvalid_i && !StallD_i;
            default: issue_c = 1'b0;
         endcase
      end
   end

   assign hs_c       = issue_c & ImemReady_i;
   assign resp_c     = (state_q == ST_WAIT) & ImemRvalid_i;
   assign ImemReq_o  = issue_c;
   assign ImemAddr_o = {pcf_q, 2'b00};

   // Next-state for FSM, PC, hold buffer and F->D register.
   always_comb begin
      state_d   = state_q;
      pcf_d     = pcf_q;
      req_pc_d  = req_pc_q;
      h_instr_d = h_instr_q;
      h_pc_d    = h_pc_q;
      h_valid_d = h_valid_q;
      instr_d_d = instr_d_q;
      pcd_d     = pcd_q;
      pcp4d_d   = pcp4d_q;
      valid_d_d = valid_d_q;

      if (PCSrcE_i) begin
         // Redirect: restart at target; an in-flight request must be drained in KILL.
         pcf_d     = PCTargetE_i[XLEN-1:2];
         h_valid_d = 1'b0;
         case (state_q)
            ST_WAIT: state_d = ImemRvalid_i ? ST_REQ : ST_KILL;
            ST_REQ:  state_d = ST_REQ;
            ST_KILL: state_d = ST_KILL;
            default: state_d = ST_REQ;
         endcase
      end else begin
         if (hs_c) begin
            pcf_d    = pcf_q + WORD_W'(1);
            req_pc_d = {pcf_q, 2'b00};
         end

         case (state_q)
            ST_REQ: begin
               if (hs_c) state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (ImemRvalid_i) state_d = hs_c ? ST_WAIT : ST_REQ;
            end
            ST_KILL: begin
               // Wait for the stale response so it cannot pose as a new one.
               if (ImemRvalid_i) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
         endcase

         // Capture a response decode cannot take; release it once decode frees up.
         if (resp_c && StallD_i && !FlushD_i) begin
            h_valid_d = 1'b1;
            h_instr_d = ImemRdata_i;
            h_pc_d    = req_pc_q;
         end else if (h_valid_q && !StallD_i && !FlushD_i) begin
            h_valid_d = 1'b0;
         end
      end

      // F->D register: bubble > hold > buffered > fresh response > bubble.
      if (PCSrcE_i || FlushD_i) begin
         instr_d_d = NOP_INSTR;
         pcd_d     = '0;
         pcp4d_d   = '0;
         valid_d_d = 1'b0;
      end else if (StallD_i) begin
         instr_d_d = instr_d_q;
      end else if (h_valid_q) begin
         instr_d_d = h_instr_q;
         pcd_d     = h_pc_q;
         pcp4d_d   = h_pc_q + XLEN'(4);
         valid_d_d = 1'b1;
      end else if (resp_c) begin
         instr_d_d = ImemRdata_i;
         pcd_d     = req_pc_q;
         pcp4d_d   = req_pc_q + XLEN'(4);
         valid_d_d = 1'b1;
      end else begin
         instr_d_d = NOP_INSTR;
         pcd_d     = '0;
         pcp4d_d   = '0;
         valid_d_d = 1'b0;
      end
   end

   // State and pipeline registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_REQ;
         pcf_q     <= RESET_PC[XLEN-1:2];
         req_pc_q  <= '0;
         h_instr_q <= '0;
         h_pc_q    <= '0;
         h_valid_q <= 1'b0;
         instr_d_q <= NOP_INSTR;
         pcd_q     <= '0;
         pcp4d_q   <= '0;
         valid_d_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pcf_q     <= pcf_d;
         req_pc_q  <= req_pc_d;
         h_instr_q <= h_instr_d;
         h_pc_q    <= h_pc_d;
         h_valid_q <= h_valid_d;
         instr_d_q <= instr_d_d;
         pcd_q     <= pcd_d;
         pcp4d_q   <= pcp4d_d;
         valid_d_q <= valid_d_d;
      end
   end

   assign InstrD_o   = instr_d_q;
   assign PCD_o      = pcd_q;
   assign PCPlus4D_o = pcp4d_q;
   assign ValidD_o   = valid_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus a PC wrap sequence.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, pcsrc;
   logic [31:0] tgt;
   logic        ready, rvalid;
   logic [31:0] rdata;

   logic        req_a, req_b;
   logic [31:0] addr_a, addr_b;
   logic [31:0] instr_a, instr_b, pcd_a, pcd_b, pcp4_a, pcp4_b;
   logic        valid_a, valid_b;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   fetch_stage u_dut (
      .clk(clk), .rst(rst), .StallD_i(stall), .FlushD_i(flush),
      .PCSrcE_i(pcsrc), .PCTargetE_i(tgt),
      .ImemReq_o(req_a), .ImemAddr_o(addr_a), .ImemReady_i(ready),
      .ImemRvalid_i(rvalid), .ImemRdata_i(rdata),
      .InstrD_o(instr_a), .PCD_o(pcd_a), .PCPlus4D_o(pcp4_a), .ValidD_o(valid_a)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(rst), .StallD_i(stall), .FlushD_i(flush),
      .PCSrcE_i(pcsrc), .PCTargetE_i(tgt),
      .ImemReq_o(req_b), .ImemAddr_o(addr_b), .ImemReady_i(ready),
      .ImemRvalid_i(rvalid), .ImemRdata_i(rdata),
      .InstrD_o(instr_b), .PCD_o(pcd_b), .PCPlus4D_o(pcp4_b), .ValidD_o(valid_b)
   );

   typedef struct {
      logic        rst;
      logic        stall;
      logic        flush;
      logic        pcsrc;
      logic [31:0] tgt;
      logic        ready;
      logic        rvalid;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic [31:0] e_instr;
      logic [31:0] e_pcd;
      logic        e_valid;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic r, input logic s, input logic f, input logic p,
                               input logic [31:0] t, input logic rd, input logic rv,
                               input logic [31:0] d, input logic eq, input logic [31:0] ea,
                               input logic [31:0] ei, input logic [31:0] ep, input logic ev);
      vec_t v;
      v.rst = r; v.stall = s; v.flush = f; v.pcsrc = p; v.tgt = t;
      v.ready = rd; v.rvalid = rv; v.rdata = d;
      v.e_req = eq; v.e_addr = ea; v.e_instr = ei; v.e_pcd = ep; v.e_valid = ev;
      return v;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [31:0] e_p4;
      rst = 1'b1; stall = 1'b0; flush = 1'b0; pcsrc = 1'b0; tgt = '0;
      ready = 1'b1; rvalid = 1'b0; rdata = '0;

      //            rst s f p tgt           rdy rv rdata          req addr          instr          pcd           v
      vecs[0]  = mk(1, 0,0,0, 32'h0,        1, 0, 32'h0,          0, 32'h0,         32'h13,        32'h0,        0);
      vecs[1]  = mk(0, 0,0,0, 32'h0,        1, 0, 32'h0,          1, 32'h0,         32'h13,        32'h0,        0);
      vecs[2]  = mk(0, 0,0,0, 32'h0,        1, 1, 32'h100,        1, 32'h4,         32'h100,       32'h0,        1);
      vecs[3]  = mk(0, 0,0,0, 32'h0,        1, 1, 32'h101,        1, 32'h8,         32'h101,       32'h4,        1);
      vecs[4]  = mk(0, 0,0,0, 32'h0,        1, 1, 32'h102,        1, 32'hC,         32'h102,       32'h8,        1);
      // stall 3 cycles while 0xAAAA_0013 returns
      vecs[5]  = mk(0, 1,0,0, 32'h0,        1, 1, 32'hAAAA_0013,  0, 32'h0,         32'h102,       32'h8,        1);
      vecs[6]  = mk(0, 1,0,0, 32'h0,        1, 0, 32'h0,          0, 32'h0,         32'h102,       32'h8,        1);
      vecs[7]  = mk(0, 1,0,0, 32'h0,        1, 0, 32'h0,          0, 32'h0,         32'h102,       32'h8,        1);
      vecs[8]  = mk(0, 0,0,0, 32'h0,        1, 0, 32'h0,          0, 32'h0,         32'hAAAA_0013, 32'hC,        1);
      vecs[9]  = mk(0, 0,0,0, 32'h0,        1, 0, 32'h0,          1, 32'h10,        32'h13,        32'h0,        0);
      vecs[10] = mk(0, 0,0,0, 32'h0,        1, 1, 32'h104,        1, 32'h14,        32'h104,       32'h10,       1);
      // memory not ready
      vecs[11] = mk(0, 0,0,0, 32'h0,        0, 1, 32'h105,        1, 32'h18,        32'h105,       32'h14,       1);
      vecs[12] = mk(0, 0,0,0, 32'h0,        1, 0, 32'h0,          1, 32'h18,        32'h13,        32'h0,        0);
      vecs[13] = mk(0, 0,0,0, 32'h0,        1, 1, 32'h106,        1, 32'h1C,        32'h106,       32'h18,       1);
      vecs[14] = mk(0, 0,0,0, 32'h0,        1, 1, 32'h107,        1, 32'h20,        32'h107,       32'h1C,       1);
      // redirect to 0x400 while 0x20 outstanding, late response killed
      vecs[15] = mk(0, 0,0,1, 32'h400,      1, 0, 32'h0,          0, 32'h0,         32'h13,        32'h0,        0);
      vecs[16] = mk(0, 0,0,0, 32'h0,        1, 0, 32'h0,          0, 32'h0,         32'h13,        32'h0,        0);
      vecs[17] = mk(0, 0,0,0, 32'h0,        1, 1, 32'hDEAD_0013,  0, 32'h0,         32'h13,        32'h0,        0);
      vecs[18] = mk(0, 0,0,0, 32'h0,        1, 0, 32'h0,          1, 32'h400,       32'h13,        32'h0,        0);
      vecs[19] = mk(0, 0,0,0, 32'h0,        1, 1, 32'h200,        1, 32'h404,       32'h200,       32'h400,      1);
      // redirect with Rvalid, unaligned target
      vecs[20] = mk(0, 0,0,1, 32'h803,      1, 1, 32'h201,        0, 32'h0,         32'h13,        32'h0,        0);
      vecs[21] = mk(0, 0,0,0, 32'h0,        1, 0, 32'h0,          1, 32'h800,       32'h13,        32'h0,        0);
      vecs[22] = mk(0, 0,0,0, 32'h0,        1, 1, 32'h300,        1, 32'h804,       32'h300,       32'h800,      1);
      // flush together with stall, then flush alone
      vecs[23] = mk(0, 1,1,0, 32'h0,        1, 1, 32'h301,        0, 32'h0,         32'h13,        32'h0,        0);
      vecs[24] = mk(0, 0,0,0, 32'h0,        1, 0, 32'h0,          1, 32'h808,       32'h13,        32'h0,        0);
      vecs[25] = mk(0, 0,1,0, 32'h0,        1, 1, 32'h302,        1, 32'h80C,       32'h13,        32'h0,        0);
      vecs[26] = mk(0, 0,0,0, 32'h0,        1, 1, 32'h303,        1, 32'h810,       32'h303,       32'h80C,      1);
      vecs[27] = mk(0, 0,0,0, 32'h0,        1, 0, 32'h0,          0, 32'h0,         32'h13,        32'h0,        0);
      vecs[28] = mk(0, 0,0,0, 32'h0,        1, 1, 32'h304,        1, 32'h814,       32'h304,       32'h810,      1);
      // redirect overrides stall
      vecs[29] = mk(0, 1,0,1, 32'h40,       1, 1, 32'h305,        0, 32'h0,         32'h13,        32'h0,        0);
      vecs[30] = mk(0, 0,0,0, 32'h0,        1, 0, 32'h0,          1, 32'h40,        32'h13,        32'h0,        0);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst = vecs[i].rst; stall = vecs[i].stall; flush = vecs[i].flush;
         pcsrc = vecs[i].pcsrc; tgt = vecs[i].tgt; ready = vecs[i].ready;
         rvalid = vecs[i].rvalid; rdata = vecs[i].rdata;
         #1;
         check32($sformatf("v%0d req", i), 32'(req_a), 32'(vecs[i].e_req));
         if (vecs[i].e_req)
            check32($sformatf("v%0d addr", i), addr_a, vecs[i].e_addr);
         @(posedge clk);
         #1;
         e_p4 = vecs[i].e_valid ? vecs[i].e_pcd + 32'd4 : 32'd0;
         check32($sformatf("v%0d instr", i), instr_a, vecs[i].e_instr);
         check32($sformatf("v%0d pcd", i), pcd_a, vecs[i].e_pcd);
         check32($sformatf("v%0d pcplus4", i), pcp4_a, e_p4);
         check32($sformatf("v%0d valid", i), 32'(valid_a), 32'(vecs[i].e_valid));
      end

      // PC wrap from RESET_PC = 0xFFFF_FFFC
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; flush = 1'b0; pcsrc = 1'b0; tgt = '0;
      ready = 1'b1; rvalid = 1'b0; rdata = '0;
      #1;
      check32("wrap req in reset", 32'(req_b), 32'd0);
      @(posedge clk); #1;
      check32("wrap reset instr", instr_b, 32'h13);
      check32("wrap reset valid", 32'(valid_b), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check32("wrap first req", 32'(req_b), 32'd1);
      check32("wrap first addr", addr_b, 32'hFFFF_FFFC);
      @(posedge clk);
      @(negedge clk);
      rvalid = 1'b1; rdata = 32'h0000_0055;
      #1;
      check32("wrap second addr", addr_b, 32'h0000_0000);
      @(posedge clk); #1;
      check32("wrap instr", instr_b, 32'h0000_0055);
      check32("wrap pcd", pcd_b, 32'hFFFF_FFFC);
      check32("wrap pcplus4", pcp4_b, 32'h0000_0000);
      check32("wrap valid", 32'(valid_b), 32'd1);
      @(negedge clk);
      rvalid = 1'b0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
